// File: rtl/regs_mp_sb_if.sv
// Port bundle for regs_mp_sb: write ports, read ports, scoreboard and clear-engine signals.
interface regs_mp_sb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [NUM_WR-1:0]                 we;
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wdata;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]                 rbusy;
  logic                              busy_set;
  logic [ADDR_WIDTH-1:0]             busy_addr;
  logic [NUM_REGS-1:0]               busy_q;
  logic                              clr_req;
  logic                              clr_active;
  logic                              clr_done;

  modport master (
    output we, waddr, wdata, raddr, busy_set, busy_addr, clr_req,
    input  rdata, rbusy, busy_q, clr_active, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr, busy_set, busy_addr, clr_req,
    output rdata, rbusy, busy_q, clr_active, clr_done
  );
endinterface

// File: rtl/regs_mp_sb.sv
// Multi-port register file with same-cycle bypass, busy scoreboard and sequential clear engine.
// Reads are combinational, writes land at the next edge; a clear takes NUM_REGS+1 cycles to clr_done.
module regs_mp_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int R0_ZERO    = 1
) (
  input  logic         clk,
  input  logic         reset,
  regs_mp_sb_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]             idx_q, idx_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] gpr;
  logic [NUM_REGS-1:0]               busy_r;
  logic                              clearing;
  logic                              clr_active_c, clr_done_c;
  logic [NUM_WR-1:0]                 wr_en;
  logic                              set_en;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdata_c;
  logic [NUM_RD-1:0]                 hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clr_active_c = 1'b0;
    clr_done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        clr_active_c = 1'b1;
        // Stop on the last register rather than letting idx wrap.
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + ADDR_WIDTH'(1);
      end
      DONE: begin
        clr_done_c = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clearing = (state_q == CLEAR);

  // Qualified write/set enables: blocked while clearing and for R0 when it is hardwired.
  always_comb begin
    wr_en = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_en[j] = bus.we[j] && !clearing &&
                 !((R0_ZERO != 0) && (bus.waddr[j] == '0));
    end
  end

  assign set_en = bus.busy_set && !clearing &&
                  !((R0_ZERO != 0) && (bus.busy_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr    <= '0;
      busy_r <= '0;
    end else if (clearing) begin
      gpr[idx_q]    <= '0;
      busy_r[idx_q] <= 1'b0;
    end else begin
      // Ascending port order lets the highest-index port win a collision.
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) begin
          gpr[bus.waddr[j]]    <= bus.wdata[j];
          busy_r[bus.waddr[j]] <= 1'b0;
        end
      end
      if (set_en) busy_r[bus.busy_addr] <= 1'b1;
    end
  end

  always_comb begin
    rdata_c = '0;
    hit     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata_c[i] = gpr[bus.raddr[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (bus.waddr[j] == bus.raddr[i])) begin
            rdata_c[i] = bus.wdata[j];
            hit[i]     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rbusy[i] = busy_r[bus.raddr[i]] & ~hit[i];
    end
  end

  assign bus.rdata      = rdata_c;
  assign bus.busy_q     = busy_r;
  assign bus.clr_active = clr_active_c;
  assign bus.clr_done   = clr_done_c;
endmodule

// File: tb/tb_regs_mp_sb.sv
// Randomized and directed bench for regs_mp_sb against an array-based reference model.
module tb_regs_mp_sb;
  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int NR  = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [DW-1:0] m_gpr  [NR];
  logic          m_busy [NR];
  int            clr_cnt;   // 0 idle, 1..NR clearing reg clr_cnt-1, NR+1 done

  always #5 clk = ~clk;

  regs_mp_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();
  regs_mp_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus_nb ();

  regs_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR),
               .BYPASS(1), .R0_ZERO(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  regs_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NRD), .NUM_WR(NWR),
               .BYPASS(0), .R0_ZERO(1)) dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

  assign bus_nb.we        = bus.we;
  assign bus_nb.waddr     = bus.waddr;
  assign bus_nb.wdata     = bus.wdata;
  assign bus_nb.raddr     = bus.raddr;
  assign bus_nb.busy_set  = bus.busy_set;
  assign bus_nb.busy_addr = bus.busy_addr;
  assign bus_nb.clr_req   = bus.clr_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    bus.we        = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.raddr     = '0;
    bus.busy_set  = 1'b0;
    bus.busy_addr = '0;
    bus.clr_req   = 1'b0;
  endtask

  task automatic model_zero();
    for (int k = 0; k < NR; k++) begin
      m_gpr[k]  = '0;
      m_busy[k] = 1'b0;
    end
    clr_cnt = 0;
  endtask

  function automatic bit in_clear();
    return (clr_cnt >= 1) && (clr_cnt <= NR);
  endfunction

  // One clock: check combinational reads, advance the model at the edge, check registered outputs.
  task automatic step();
    logic [DW-1:0] ed;
    logic          eb;
    logic [NR-1:0] ebv;
    int            a;
    #1;
    for (int i = 0; i < NRD; i++) begin
      a  = int'(bus.raddr[i]);
      ed = m_gpr[a];
      eb = m_busy[a];
      if (!in_clear()) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.we[j] && bus.waddr[j] == bus.raddr[i] && bus.waddr[j] != '0) begin
            ed = bus.wdata[j];
            eb = 1'b0;
          end
        end
      end
      check("rdata", 32'(bus.rdata[i]), 32'(ed));
      check("rbusy", 32'(bus.rbusy[i]), 32'(eb));
    end
    @(posedge clk);
    if (in_clear()) begin
      m_gpr[clr_cnt-1]  = '0;
      m_busy[clr_cnt-1] = 1'b0;
      clr_cnt++;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.waddr[j] != '0) begin
          m_gpr[int'(bus.waddr[j])]  = bus.wdata[j];
          m_busy[int'(bus.waddr[j])] = 1'b0;
        end
      end
      if (bus.busy_set && bus.busy_addr != '0) m_busy[int'(bus.busy_addr)] = 1'b1;
      if (clr_cnt == NR + 1) clr_cnt = 0;
      else if (bus.clr_req)  clr_cnt = 1;
    end
    #1;
    for (int k = 0; k < NR; k++) ebv[k] = m_busy[k];
    check("busy_q", 32'(bus.busy_q), 32'(ebv));
    check("clr_active", 32'(bus.clr_active), 32'(in_clear()));
    check("clr_done", 32'(bus.clr_done), 32'(clr_cnt == NR + 1));
    @(negedge clk);
  endtask

  // Runs a full clear sequence from the cycle after clr_req; returns active/done counts.
  task automatic run_clear(input int mid_k, output int act, output int done_at);
    act     = 0;
    done_at = 0;
    for (int k = 1; k <= NR + 1; k++) begin
      idle();
      bus.raddr[0] = AW'(6);
      bus.raddr[1] = AW'(7);
      if (bus.clr_active) act++;
      if (bus.clr_done) done_at = k;
      if (k == mid_k) begin
        bus.we[0]     = 1'b1;
        bus.waddr[0]  = AW'(6);
        bus.wdata[0]  = DW'('hAA);
        bus.busy_set  = 1'b1;
        bus.busy_addr = AW'(7);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int act, done_at;
    reset = 1'b1;
    idle();
    model_zero();
    #12;
    for (int a = 0; a < NR; a++) begin
      bus.raddr[0] = AW'(a);
      bus.raddr[1] = AW'(a);
      #1;
      check("rst_rdata0", 32'(bus.rdata[0]), 'h0);
      check("rst_rdata1", 32'(bus.rdata[1]), 'h0);
      check("rst_rbusy", 32'(bus.rbusy), 'h0);
    end
    check("rst_busy_q", 32'(bus.busy_q), 'h0);
    check("rst_clr_active", 32'(bus.clr_active), 'h0);
    check("rst_clr_done", 32'(bus.clr_done), 'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Same-cycle bypass vs no-bypass instance
    bus.we[0] = 1'b1; bus.waddr[0] = AW'(3); bus.wdata[0] = DW'('h5A); bus.raddr[1] = AW'(3);
    #1;
    check("byp_same", 32'(bus.rdata[1]), 'h5A);
    check("nobyp_same", 32'(bus_nb.rdata[1]), 'h00);
    step();
    idle(); bus.raddr[1] = AW'(3);
    #1;
    check("byp_next", 32'(bus.rdata[1]), 'h5A);
    check("nobyp_next", 32'(bus_nb.rdata[1]), 'h5A);
    step();

    // Collision: highest port wins; R0 stays zero
    idle();
    bus.we = 2'b11; bus.waddr[0] = AW'(5); bus.waddr[1] = AW'(5);
    bus.wdata[0] = DW'('h11); bus.wdata[1] = DW'('h22); bus.raddr[0] = AW'(5);
    step();
    idle(); bus.raddr[0] = AW'(5);
    #1;
    check("collide", 32'(bus.rdata[0]), 'h22);
    step();
    idle(); bus.we[0] = 1'b1; bus.waddr[0] = '0; bus.wdata[0] = DW'('hFF);
    #1;
    check("r0_same", 32'(bus.rdata[0]), 'h00);
    step();
    idle();
    #1;
    check("r0_next", 32'(bus.rdata[0]), 'h00);
    step();

    // Scoreboard set / clear / set-wins
    idle(); bus.busy_set = 1'b1; bus.busy_addr = AW'(4);
    step();
    check("sb_set", 32'(bus.busy_q[4]), 'h1);
    idle(); bus.raddr[0] = AW'(4);
    #1;
    check("sb_rbusy", 32'(bus.rbusy[0]), 'h1);
    step();
    idle(); bus.we[0] = 1'b1; bus.waddr[0] = AW'(4); bus.wdata[0] = DW'('h33); bus.raddr[0] = AW'(4);
    #1;
    check("sb_rbusy_byp", 32'(bus.rbusy[0]), 'h0);
    step();
    check("sb_wr_clear", 32'(bus.busy_q[4]), 'h0);
    idle(); bus.busy_set = 1'b1; bus.busy_addr = AW'(4);
    bus.we[1] = 1'b1; bus.waddr[1] = AW'(4); bus.wdata[1] = DW'('h44);
    step();
    check("sb_set_wins", 32'(bus.busy_q[4]), 'h1);
    idle(); bus.busy_set = 1'b1; bus.busy_addr = '0;
    step();
    check("sb_r0", 32'(bus.busy_q[0]), 'h0);

    // Full clear with a write/set issued mid-sequence
    for (int a = 1; a < NR; a++) begin
      idle(); bus.we[0] = 1'b1; bus.waddr[0] = AW'(a); bus.wdata[0] = DW'($urandom_range(1, 255));
      bus.busy_set = 1'b1; bus.busy_addr = AW'(NR - a);
      step();
    end
    idle(); bus.clr_req = 1'b1;
    step();
    run_clear(3, act, done_at);
    check("clr_active_len", 32'(act), 32'(NR));
    check("clr_done_at", 32'(done_at), 32'(NR + 1));
    idle();
    for (int a = 0; a < NR; a++) begin
      bus.raddr[0] = AW'(a);
      #1;
      check("clr_reg_zero", 32'(bus.rdata[0]), 'h0);
    end
    check("clr_busy_zero", 32'(bus.busy_q), 'h0);
    step();

    // Reset on clear cycle 3, then restart from index 0
    idle(); bus.we[0] = 1'b1; bus.waddr[0] = AW'(2); bus.wdata[0] = DW'('h77);
    bus.busy_set = 1'b1; bus.busy_addr = AW'(5);
    step();
    idle(); bus.clr_req = 1'b1;
    step();
    idle();
    step();
    step();
    #1 reset = 1'b1;
    model_zero();
    #1;
    check("abort_active", 32'(bus.clr_active), 'h0);
    check("abort_done", 32'(bus.clr_done), 'h0);
    check("abort_busy", 32'(bus.busy_q), 'h0);
    bus.raddr[0] = AW'(2);
    #1;
    check("abort_reg", 32'(bus.rdata[0]), 'h0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) step();
    idle(); bus.we[0] = 1'b1; bus.waddr[0] = AW'(7); bus.wdata[0] = DW'('h99);
    step();
    idle(); bus.clr_req = 1'b1;
    step();
    run_clear(0, act, done_at);
    check("restart_active_len", 32'(act), 32'(NR));
    check("restart_done_at", 32'(done_at), 32'(NR + 1));
    idle(); bus.raddr[1] = AW'(7);
    #1;
    check("restart_reg7", 32'(bus.rdata[1]), 'h0);
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.we = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        bus.waddr[j] = AW'($urandom_range(0, NR - 1));
        bus.wdata[j] = DW'($urandom);
      end
      for (int i = 0; i < NRD; i++) bus.raddr[i] = AW'($urandom_range(0, NR - 1));
      bus.busy_set  = ($urandom_range(0, 2) == 0);
      bus.busy_addr = AW'($urandom_range(0, NR - 1));
      bus.clr_req   = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
